// File: rtl/tdc_pkg.sv
// Shared definitions for the carry-chain TDC channel sequencer: FSM states,
// the drop counter width and a constant-friendly ceil(log2) helper.
package tdc_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARMED  = 3'd1,
      ENCODE = 3'd2,
      OUTPUT = 3'd3,
      DEAD   = 3'd4
   } tdc_state_e;

   localparam int DROP_W = 16;

   // ceil(log2(value)); returns 0 for value <= 1
   function automatic int clog2(input int value);
      int result;
      int remain;
      result = 0;
      remain = value - 1;
      while (remain > 0) begin
         result = result + 1;
         remain = remain >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/tdc_therm_ones_count.sv
// Population count of the delay-line taps. Bubbles in the thermometer code
// are simply counted, so the result is the number of ones regardless of
// where they sit. Built as a balanced pairwise adder tree.
module tdc_therm_ones_count
   import tdc_pkg::*;
#(
   parameter int NTAPS  = 32,
   parameter int FINE_W = 6
) (
   input  logic [NTAPS-1:0]  taps_i,
   output logic [FINE_W-1:0] ones_o
);

   localparam int LEAVES = 1 << clog2(NTAPS);

   logic [FINE_W-1:0] node [LEAVES];

   // Leaves hold single taps (padding leaves are zero); each level then sums
   // adjacent pairs in place until the root sits in node[0]
   always_comb begin
      node = '{default: '0};
      for (int i = 0; i < NTAPS; i++) begin
         node[i] = FINE_W'(taps_i[i]);
      end
      for (int w = LEAVES / 2; w >= 1; w = w / 2) begin
         for (int i = 0; i < w; i++) begin
            node[i] = node[2*i] + node[2*i+1];
         end
      end
      ones_o = node[0];
   end

endmodule

// File: rtl/tdc_channel_ctrl.sv
// Sequencer for one carry-chain TDC channel. Double-registers the delay-line
// taps, detects a rising tap 0, captures taps and coarse time, encodes the
// fine code by ones-count and offers the timestamp on a valid/ready port,
// then holds off for a dead time. Also drives the calibration trigger.
module tdc_channel_ctrl
   import tdc_pkg::*;
#(
   parameter int NTAPS       = 32,
   parameter int FINE_W      = 6,
   parameter int COARSE_W    = 24,
   parameter int DEAD_CYCLES = 4,
   parameter int CALP_W      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NTAPS-1:0]    taps_in,
   input  logic                enable,
   input  logic                cal_mode,
   input  logic [CALP_W-1:0]   cal_period,
   output logic                trig_sel,
   output logic                cal_pulse,
   output logic                ts_valid,
   input  logic                ts_ready,
   output logic [FINE_W-1:0]   ts_fine,
   output logic [COARSE_W-1:0] ts_coarse,
   output logic                ts_cal,
   output logic [DROP_W-1:0]   drop_cnt,
   output logic                busy
);

   localparam int DCNT_W = clog2(DEAD_CYCLES) + 1;

   if (FINE_W < clog2(NTAPS + 1)) begin : gFineWidthCheck
      $error("FINE_W cannot represent a fine code of NTAPS");
   end

   tdc_state_e          state_q, state_d;
   logic [NTAPS-1:0]    taps_q1, taps_q2, capTaps_q;
   logic                tap0Prev_q;
   logic [COARSE_W-1:0] coarseCnt_q, coarse_q1, coarse_q2, capCoarse_q, tsCoarse_q;
   logic                capCal_q, tsCal_q, trigSel_q, calPulse_q;
   logic [FINE_W-1:0]   tsFine_q, onesCount;
   logic [DROP_W-1:0]   dropCnt_q;
   logic [CALP_W-1:0]   calCnt_q, calPeriod_q;
   logic [DCNT_W-1:0]   deadCnt_q;
   logic                hit, deadDone, calActive, captureEn, encodeEn;

   assign hit       = taps_q2[0] & ~tap0Prev_q;
   assign deadDone  = (deadCnt_q == DCNT_W'(DEAD_CYCLES - 1));
   assign calActive = trigSel_q && (state_q == ARMED);

   tdc_therm_ones_count #(
      .NTAPS  (NTAPS),
      .FINE_W (FINE_W)
   ) uOnesCount (
      .taps_i (capTaps_q),
      .ones_o (onesCount)
   );

   // Metastability pair on the taps with the coarse count kept in lockstep
   always_ff @(posedge clk) begin
      if (rst) begin
         taps_q1     <= '0;
         taps_q2     <= '0;
         tap0Prev_q  <= 1'b0;
         coarseCnt_q <= '0;
         coarse_q1   <= '0;
         coarse_q2   <= '0;
      end else begin
         taps_q1     <= taps_in;
         taps_q2     <= taps_q1;
         tap0Prev_q  <= taps_q2[0];
         coarseCnt_q <= coarseCnt_q + COARSE_W'(1);
         coarse_q1   <= coarseCnt_q;
         coarse_q2   <= coarse_q1;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and the outputs that decode directly from the state
   always_comb begin
      state_d   = state_q;
      captureEn = 1'b0;
      encodeEn  = 1'b0;
      ts_valid  = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) state_d = ARMED;
         end
         ARMED: begin
            if (hit) begin
               state_d   = ENCODE;
               captureEn = 1'b1;
            end else if (!enable) begin
               state_d = IDLE;
            end
         end
         ENCODE: begin
            busy     = 1'b1;
            encodeEn = 1'b1;
            state_d  = OUTPUT;
         end
         OUTPUT: begin
            busy     = 1'b1;
            ts_valid = 1'b1;
            if (ts_ready) state_d = DEAD;
         end
         DEAD: begin
            busy = 1'b1;
            if (deadDone && !taps_q2[0]) state_d = enable ? ARMED : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Snapshot taps, coarse time and trigger source on the hit, then encode
   always_ff @(posedge clk) begin
      if (rst) begin
         capTaps_q   <= '0;
         capCoarse_q <= '0;
         capCal_q    <= 1'b0;
         tsFine_q    <= '0;
         tsCoarse_q  <= '0;
         tsCal_q     <= 1'b0;
      end else begin
         if (captureEn) begin
            capTaps_q   <= taps_q2;
            capCoarse_q <= coarse_q2;
            capCal_q    <= trigSel_q;
         end
         if (encodeEn) begin
            tsFine_q   <= onesCount;
            tsCoarse_q <= capCoarse_q;
            tsCal_q    <= capCal_q;
         end
      end
   end

   // Dead-time counter runs only in DEAD and parks at its terminal value
   always_ff @(posedge clk) begin
      if (rst || state_q != DEAD) begin
         deadCnt_q <= '0;
      end else if (!deadDone) begin
         deadCnt_q <= deadCnt_q + DCNT_W'(1);
      end
   end

   // Hits arriving while busy are lost; count them, saturating
   always_ff @(posedge clk) begin
      if (rst) begin
         dropCnt_q <= '0;
      end else if (hit && busy && dropCnt_q != {DROP_W{1'b1}}) begin
         dropCnt_q <= dropCnt_q + DROP_W'(1);
      end
   end

   // Trigger source only changes while no capture can be in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         trigSel_q <= 1'b0;
      end else if (state_q == IDLE || (state_q == ARMED && !hit)) begin
         trigSel_q <= cal_mode;
      end
   end

   // Calibration pulse generator; period is latched on each reload
   always_ff @(posedge clk) begin
      if (rst) begin
         calCnt_q    <= '0;
         calPeriod_q <= '0;
         calPulse_q  <= 1'b0;
      end else if (!calActive) begin
         calCnt_q    <= '0;
         calPeriod_q <= cal_period;
         calPulse_q  <= 1'b0;
      end else if (calCnt_q == calPeriod_q) begin
         calCnt_q    <= '0;
         calPeriod_q <= cal_period;
         calPulse_q  <= 1'b1;
      end else begin
         calCnt_q   <= calCnt_q + CALP_W'(1);
         calPulse_q <= 1'b0;
      end
   end

   assign trig_sel  = trigSel_q;
   assign cal_pulse = calPulse_q;
   assign ts_fine   = tsFine_q;
   assign ts_coarse = tsCoarse_q;
   assign ts_cal    = tsCal_q;
   assign drop_cnt  = dropCnt_q;

endmodule
